pwm_ramp_controller: RTL and testbench

PWM_RAMP_CONTROLLER -- requirements
Module: pwm_ramp_controller

---
 rtl/pwm_ctrl_pkg.sv | 19 +
 rtl/pwm_period_tracker.sv | 41 ++++
 rtl/pwm_ramp_controller.sv | 148 ++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_ctrl_pkg.sv
// Purpose : shared types and defaults for the pwm duty-ramp scheduler blocks.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: ramp_state_t (IDLE/RAMP), default duty width N and rate width R.
package pwm_ctrl_pkg;

  // Default duty width; must match the N of the pwm instance being driven.
  localparam int unsigned PWM_N_DEFAULT = 4;

  // Default width of the rate field (pwm periods per LSB, minus one).
  localparam int unsigned PWM_R_DEFAULT = 8;

  // IDLE: duty already equals the target. RAMP: duty is walking toward it.
  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } ramp_state_t;

endpackage

// File: rtl/pwm_period_tracker.sv
// Purpose : mirrors the pwm phase counter and flags the last step of each pwm period.
// Latency : period_end is combinational from ena/step in the cycle where phase = 2^N-1.
// Backpressure: none; ena=0 freezes the phase and forces period_end low.
//
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset, clears the phase
//   ena        - global enable; phase advances only when high
//   step       - single-cycle pwm counter advance pulse (same net as pwm.step)
//   period_end - high for the step that wraps the phase back to zero
module pwm_period_tracker
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned N = PWM_N_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic step,
  output logic period_end
);

  logic [N-1:0] phase;
  logic         advance;

  // A step is only counted when the block is enabled and out of reset, so the
  // phase stays in lock-step with the pwm counter it shadows.
  assign advance = ena && step && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= '0;
    end else if (advance) begin
      phase <= phase + 1'b1;
    end
  end

  // The step that takes phase from all-ones back to zero closes a period.
  assign period_end = advance && (phase == {N{1'b1}});

endmodule

// File: rtl/pwm_ramp_controller.sv
// Purpose : walks the pwm duty toward a requested target, one LSB every (rate+1) pwm periods.
// Latency : accept takes effect at the next edge; duty only changes on period_end edges.
// Backpressure: target_ready = ena & !rst (& !kill when PWM_RAMP_KILL_EN); no internal queueing.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   ena               - global enable; everything holds while low
//   step              - pwm counter advance pulse, shared with the pwm
//   target_duty/valid - requested final duty, handshaked with target_ready
//   rate              - pwm periods per one-LSB duty change, minus one
//   kill              - emergency off (active only with PWM_RAMP_KILL_EN defined)
//   duty              - registered duty for pwm.duty
//   busy              - high while ramping
//   period_end        - single-cycle pulse at each pwm period boundary
//
// Build option: define PWM_RAMP_KILL_EN to make kill force duty/target to zero
// immediately. Without it the kill port is present but has no effect.
module pwm_ramp_controller
  import pwm_ctrl_pkg::*;
#(
  parameter int unsigned N = PWM_N_DEFAULT,
  parameter int unsigned R = PWM_R_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         step,
  input  logic [N-1:0] target_duty,
  input  logic         target_valid,
  output logic         target_ready,
  input  logic [R-1:0] rate,
  input  logic         kill,
  output logic [N-1:0] duty,
  output logic         busy,
  output logic         period_end
);

  ramp_state_t  state;
  logic [N-1:0] duty_q;
  logic [N-1:0] target_q;
  logic [R-1:0] rate_cnt;

  logic         kill_act;
  logic         accept;
  logic [N-1:0] eff_target;
  logic         moving;
  logic         going_up;
  logic         rate_hit;
  logic [N-1:0] duty_stepped;

  // ---------------------------------------------------------------------------
  // Period boundary detection, shared with other pwm schedulers.
  // ---------------------------------------------------------------------------
  pwm_period_tracker #(
    .N (N)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .ena        (ena),
    .step       (step),
    .period_end (period_end)
  );

`ifdef PWM_RAMP_KILL_EN
  assign kill_act = kill;
`else
  // kill is deliberately ignored in this build.
  logic unused_kill;
  assign unused_kill = kill;
  assign kill_act    = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Target handshake
  // ---------------------------------------------------------------------------
  assign target_ready = ena && !rst && !kill_act;
  assign accept       = target_valid && target_ready;

  // A target accepted this cycle already steers a coincident period_end, so
  // direction and end-of-ramp tests look through to the incoming value.
  assign eff_target = accept ? target_duty : target_q;
  assign moving     = (eff_target != duty_q);
  assign going_up   = (eff_target > duty_q);

  // Greater-or-equal rather than equal: if rate is lowered below the current
  // count, the next comparison still fires instead of running the counter
  // all the way around.
  assign rate_hit = (rate_cnt >= rate);

  // One LSB toward the target, clamped at both rails so duty can never wrap.
  always_comb begin
    duty_stepped = duty_q;
    if (going_up) begin
      if (duty_q != {N{1'b1}}) begin
        duty_stepped = duty_q + 1'b1;
      end
    end else begin
      if (duty_q != '0) begin
        duty_stepped = duty_q - 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Ramp state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      rate_cnt <= '0;
    end else if (kill_act) begin
      // Emergency off does not wait for a period boundary.
      state    <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      rate_cnt <= '0;
    end else if (ena) begin
      if (accept) begin
        target_q <= target_duty;
      end

      if (!moving) begin
        // Parking in IDLE always leaves the rate counter at zero, so a fresh
        // ramp starts a full rate interval; a retarget during RAMP keeps it.
        state    <= IDLE;
        rate_cnt <= '0;
      end else if (period_end) begin
        if (rate_hit) begin
          rate_cnt <= '0;
          duty_q   <= duty_stepped;
          state    <= (duty_stepped == eff_target) ? IDLE : RAMP;
        end else begin
          rate_cnt <= rate_cnt + 1'b1;
          state    <= RAMP;
        end
      end else begin
        state <= RAMP;
      end
    end
  end

  assign duty = duty_q;
  // Gated with rst so busy reads low throughout a reset cycle.
  assign busy = (state == RAMP) && !rst;

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Purpose : directed self-checking bench for pwm_ramp_controller (N=4, R=8).
// Expected duty steps are queued with the period_end index at which each must
// land; a negedge monitor pops and compares them whenever duty moves.
module tb_pwm_ramp_controller;

  localparam int N = 4;
  localparam int R = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ena = 1'b1;
  logic         step = 1'b1;
  logic [N-1:0] target_duty = '0;
  logic         target_valid = 1'b0;
  logic [R-1:0] rate = '0;
  logic         kill = 1'b0;
  logic         target_ready;
  logic [N-1:0] duty;
  logic         busy;
  logic         period_end;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int duty;
    int pe_at;
  } exp_t;

  exp_t exp_q[$];
  int   pe_total = 0;
  logic last_pe = 1'b0;
  logic last_rst = 1'b1;
  logic last_kill = 1'b0;
  logic [N-1:0] prev_duty = '0;

  always #5 clk = ~clk;

  pwm_ramp_controller #(.N(N), .R(R)) dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .step         (step),
    .target_duty  (target_duty),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .rate         (rate),
    .kill         (kill),
    .duty         (duty),
    .busy         (busy),
    .period_end   (period_end)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
    end
  endtask

  // Queue the duty values from 'from' (exclusive) to 'stop' (inclusive); the
  // k-th step must land on period_end number base + k*(r+1).
  task automatic push_ramp(input int from, input int stop, input int r, input int base);
    int   d;
    int   k;
    exp_t e;
    d = from;
    k = 0;
    while (d != stop) begin
      d = d + ((stop > from) ? 1 : -1);
      k++;
      e.duty  = d;
      e.pe_at = base + k * (r + 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic accept_target(input int t, input int r, output int base);
    @(posedge clk); #1;
    target_duty  = N'(t);
    rate         = R'(r);
    target_valid = 1'b1;
    base         = pe_total;
    @(negedge clk);
    chk("accept_ready", target_ready, 1);
    @(posedge clk); #1;
    target_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_duty(input string tag, input int value, input int max_cycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (duty !== N'(value) && n < max_cycles);
    chk(tag, duty, value);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Duty monitor: every change outside reset/kill must follow a period_end
  // and match the next queued step at the queued period_end index.
  always @(negedge clk) begin : mon
    exp_t e;
    if (duty !== prev_duty) begin
      if (!(last_rst || last_kill)) begin
        chk("change_on_period_end", last_pe, 1);
        if (exp_q.size() == 0) begin
          chk("unexpected_change", duty, prev_duty);
        end else begin
          e = exp_q.pop_front();
          chk("ramp_duty", duty, e.duty);
          chk("ramp_pe_index", pe_total, e.pe_at);
        end
      end
      prev_duty = duty;
    end
    if (period_end === 1'b1) pe_total++;
    last_pe   = period_end;
    last_rst  = rst;
    last_kill = kill;
  end

  initial begin
    int base;
    int n;
    int bad;

    // ---- reset ----
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_ready", target_ready, 0);
    chk("rst_period_end", period_end, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_duty", duty, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_ready", target_ready, 1);

    // ---- scenario 1: 0 -> 8, rate 0 ----
    accept_target(8, 0, base);
    push_ramp(0, 8, 0, base);
    @(negedge clk);
    chk("s1_busy", busy, 1);
    wait_drain("s1_drain", 8 * 16 + 40);
    @(negedge clk);
    chk("s1_duty", duty, 8);
    chk("s1_idle", busy, 0);

    // ---- scenario 2: 8 -> 3, rate 2 ----
    accept_target(3, 2, base);
    push_ramp(8, 3, 2, base);
    wait_drain("s2_drain", 15 * 16 + 40);
    @(negedge clk);
    chk("s2_duty", duty, 3);
    chk("s2_idle", busy, 0);

    // ---- reset mid-ramp abandons the ramp ----
    accept_target(0, 0, base);
    push_ramp(3, 1, 0, base);
    wait_drain("rst_mid_drain", 2 * 16 + 40);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_ready", target_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_duty", duty, 0);
    chk("rst_mid_resume_ready", target_ready, 1);
    repeat (40) @(negedge clk);
    chk("rst_mid_hold", duty, 0);

    // ---- scenario 3: ramp toward 15, retarget to 2 at duty 5 ----
    accept_target(15, 0, base);
    push_ramp(0, 5, 0, base);
    wait_drain("s3_up_drain", 5 * 16 + 40);
    accept_target(2, 0, base);
    push_ramp(5, 2, 0, base);
    wait_drain("s3_down_drain", 3 * 16 + 40);
    @(negedge clk);
    chk("s3_duty", duty, 2);
    chk("s3_idle", busy, 0);

    // ---- scenario 4: accept 15 in the same cycle as period_end ----
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_end !== 1'b1 && n < 40);
    chk("s4_find_pe", period_end, 1);
    repeat (16) @(posedge clk);
    #1;
    target_duty  = 4'd15;
    rate         = '0;
    target_valid = 1'b1;
    base         = pe_total;
    push_ramp(2, 15, 0, base);
    @(negedge clk);
    chk("s4_pe_with_accept", period_end, 1);
    chk("s4_ready", target_ready, 1);
    @(posedge clk); #1;
    target_valid = 1'b0;
    @(negedge clk);
    chk("s4_first_step", duty, 3);
    wait_drain("s4_drain", 13 * 16 + 40);
    repeat (40) @(negedge clk);
    chk("s4_no_wrap", duty, 15);
    chk("s4_idle", busy, 0);

    // ---- scenario 5: ena low for 40 cycles mid-ramp ----
    pulse_reset();
    accept_target(10, 0, base);
    push_ramp(0, 10, 0, base);
    wait_duty("s5_reach3", 3, 100);
    // Now one cycle into a fresh period (phase 0); advance five more steps.
    repeat (5) @(posedge clk);
    #1;
    ena = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (period_end !== 1'b0 || duty !== 4'd3 || busy !== 1'b1 || target_ready !== 1'b0) bad++;
    end
    chk("s5_frozen", bad, 0);
    @(posedge clk); #1;
    ena = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_end !== 1'b1 && n < 40);
    chk("s5_resume_pe_delay", n, 16 - 5);
    wait_drain("s5_drain", 7 * 16 + 40);
    @(negedge clk);
    chk("s5_duty", duty, 10);
    chk("s5_idle", busy, 0);

    // ---- scenario 6: kill at duty 6 ----
    pulse_reset();
    accept_target(12, 0, base);
    push_ramp(0, 12, 0, base);
    wait_duty("s6_reach6", 6, 120);
    @(posedge clk); #1;
    kill = 1'b1;
    @(negedge clk);
`ifdef PWM_RAMP_KILL_EN
    chk("s6_kill_ready", target_ready, 0);
`else
    chk("s6_kill_ready", target_ready, 1);
`endif
    @(posedge clk); #1;
    kill = 1'b0;
    @(negedge clk);
`ifdef PWM_RAMP_KILL_EN
    chk("s6_kill_duty", duty, 0);
    chk("s6_kill_busy", busy, 0);
    exp_q.delete();
    repeat (40) @(negedge clk);
    chk("s6_kill_hold", duty, 0);
`else
    chk("s6_kill_duty", duty, 6);
    chk("s6_kill_busy", busy, 1);
    wait_drain("s6_drain", 6 * 16 + 40);
    @(negedge clk);
    chk("s6_final_duty", duty, 12);
    chk("s6_idle", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
